// File: rtl/carryskip_adder_pipe.sv
// carryskip_adder_pipe
//   Parametrised carry-skip adder/subtractor with a 1- or 2-stage pipeline
//   and valid/ready handshakes on both sides.
//
//   Parameters: WIDTH (multiple of 2*BLK), BLK (skip block size), PIPE (1 or 2)
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     in_valid / in_ready   operand handshake (a, b, cin, sub, sat)
//     out_valid / out_ready result handshake (sum, cout, ovf)
//   sub=1 computes a + ~b + 1 (cin ignored); sub=0 computes a + b + cin.
//   cout/ovf always describe the raw (unsaturated) result.
//
//   Optional feature macro: CSA_SATURATE_EN
//     defined   : sat=1 with signed overflow clamps sum to the signed limit
//     undefined : sat is ignored, sum is always the wrapped result
module carryskip_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4,
   parameter int PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int H  = WIDTH / 2;
   localparam int NB = H / BLK;

   // Carry-skip add of one half-word: ripple inside each block, and a block
   // whose bits all propagate forwards its carry-in directly.
   function automatic logic [H:0] half_add(input logic [H-1:0] x,
                                           input logic [H-1:0] y,
                                           input logic         c);
      logic [H-1:0] s;
      logic         bc;
      logic         rc;
      logic         p;
      s  = '0;
      bc = c;
      for (int k = 0; k < NB; k++) begin
         rc = bc;
         p  = 1'b1;
         for (int i = 0; i < BLK; i++) begin
            s[k*BLK+i] = x[k*BLK+i] ^ y[k*BLK+i] ^ rc;
            rc = (x[k*BLK+i] & y[k*BLK+i]) | (rc & (x[k*BLK+i] ^ y[k*BLK+i]));
            p  = p & (x[k*BLK+i] ^ y[k*BLK+i]);
         end
         bc = p ? bc : rc;
      end
      return {bc, s};
   endfunction

   logic [WIDTH-1:0] beff;
   logic             c0;

   assign beff = sub ? ~b : b;
   assign c0   = sub | cin;

   // Operands of the final (output) register, produced by the selected front end.
   logic             st_valid;
   logic [WIDTH-1:0] st_sum;
   logic             st_cout;
   logic             st_a_msb;
   logic             st_b_msb;
`ifdef CSA_SATURATE_EN
   logic             st_sat;
`else
   logic             sat_unused;
   assign sat_unused = sat;
`endif

   logic out_adv;
   assign out_adv = !out_valid || out_ready;

   generate
      if ((WIDTH % (2*BLK)) != 0) begin : g_bad_width
         $error("WIDTH must be a multiple of 2*BLK");
      end

      if (PIPE == 1) begin : g_p1
         logic [H:0] lo;
         logic [H:0] hi;
         always_comb begin
            lo = half_add(a[H-1:0], beff[H-1:0], c0);
            hi = half_add(a[WIDTH-1:H], beff[WIDTH-1:H], lo[H]);
         end
         assign st_valid = in_valid;
         assign st_sum   = {hi[H-1:0], lo[H-1:0]};
         assign st_cout  = hi[H];
         assign st_a_msb = a[WIDTH-1];
         assign st_b_msb = beff[WIDTH-1];
`ifdef CSA_SATURATE_EN
         assign st_sat   = sat;
`endif
         assign in_ready = out_adv;
      end else if (PIPE == 2) begin : g_p2
         logic         s1_valid;
         logic [H-1:0] s1_lo;
         logic         s1_c;
         logic [H-1:0] s1_a_hi;
         logic [H-1:0] s1_b_hi;
`ifdef CSA_SATURATE_EN
         logic         s1_sat;
`endif
         logic         s1_adv;
         logic [H:0]   lo;
         logic [H:0]   hi;

         assign s1_adv   = !s1_valid || out_adv;
         assign in_ready = s1_adv;

         always_comb begin
            lo = half_add(a[H-1:0], beff[H-1:0], c0);
            hi = half_add(s1_a_hi, s1_b_hi, s1_c);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_valid <= 1'b0;
               s1_lo    <= '0;
               s1_c     <= 1'b0;
               s1_a_hi  <= '0;
               s1_b_hi  <= '0;
`ifdef CSA_SATURATE_EN
               s1_sat   <= 1'b0;
`endif
            end else if (s1_adv) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_lo   <= lo[H-1:0];
                  s1_c    <= lo[H];
                  s1_a_hi <= a[WIDTH-1:H];
                  s1_b_hi <= beff[WIDTH-1:H];
`ifdef CSA_SATURATE_EN
                  s1_sat  <= sat;
`endif
               end
            end
         end

         assign st_valid = s1_valid;
         assign st_sum   = {hi[H-1:0], s1_lo};
         assign st_cout  = hi[H];
         assign st_a_msb = s1_a_hi[H-1];
         assign st_b_msb = s1_b_hi[H-1];
`ifdef CSA_SATURATE_EN
         assign st_sat   = s1_sat;
`endif
      end else begin : g_bad_pipe
         $error("PIPE must be 1 or 2");
      end
   endgenerate

   logic             st_ovf;
   logic [WIDTH-1:0] res_sum;

   assign st_ovf = (st_a_msb == st_b_msb) && (st_sum[WIDTH-1] != st_a_msb);

`ifdef CSA_SATURATE_EN
   // Positive overflow can only happen with a non-negative a, so a's sign picks the limit.
   assign res_sum = (st_sat && st_ovf) ?
                    (st_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                    st_sum;
`else
   assign res_sum = st_sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (out_adv) begin
         out_valid <= st_valid;
         if (st_valid) begin
            sum  <= res_sum;
            cout <= st_cout;
            ovf  <= st_ovf;
         end
      end
   end

endmodule
